// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler: green/yellow/all-red sequencing
// arbitrated between emergency pre-emption, night flash and pedestrians.
module traffic_phase_scheduler #(
  parameter int CNT_W    = 12,
  parameter int T_CLEAR  = 250,
  parameter int T_G_MIN  = 500,
  parameter int T_G1_MAX = 2500,
  parameter int T_G2_MAX = 2250,
  parameter int T_Y      = 250,
  parameter int T_FLASH  = 50
) (
  input  logic clk,
  input  logic ret,
  input  logic ped1_req,
  input  logic ped2_req,
  input  logic emg_req,
  input  logic emg_dir,
  input  logic night,
  output logic red1,
  output logic yellow1,
  output logic green1,
  output logic red2,
  output logic yellow2,
  output logic green2,
  output logic ped1_walk,
  output logic ped2_walk,
  output logic ped1_pend,
  output logic ped2_pend,
  output logic emg_active
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ALLRED,
    S_G1R2,
    S_Y1R2,
    S_R1G2,
    S_R1Y2,
    S_EMG,
    S_FLASH
  } state_e;

  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CLEAR  = CNT_W'(T_CLEAR);
  localparam logic [CNT_W-1:0] C_G_MIN  = CNT_W'(T_G_MIN);
  localparam logic [CNT_W-1:0] C_G1_MAX = CNT_W'(T_G1_MAX);
  localparam logic [CNT_W-1:0] C_G2_MAX = CNT_W'(T_G2_MAX);
  localparam logic [CNT_W-1:0] C_Y      = CNT_W'(T_Y);
  localparam logic [CNT_W-1:0] C_FLASH  = CNT_W'(T_FLASH);

  // lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
  localparam logic [5:0] L_INIT = 6'b010_010;
  localparam logic [5:0] L_AR   = 6'b100_100;
  localparam logic [5:0] L_G1   = 6'b001_100;
  localparam logic [5:0] L_Y1   = 6'b010_100;
  localparam logic [5:0] L_G2   = 6'b100_001;
  localparam logic [5:0] L_Y2   = 6'b100_010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             nxt_dir_q, nxt_dir_d;
  logic             emg_pend_q, emg_pend_d;
  logic             emg_dir_q, emg_dir_d;
  logic             ped1_pend_q, ped1_pend_d;
  logic             ped2_pend_q, ped2_pend_d;
  logic             flash_q, flash_d;
  logic [5:0]       lamp_q, lamp_d;
  logic             walk1_q, walk1_d;
  logic             walk2_q, walk2_d;
  logic             emg_act_q, emg_act_d;

  logic emg_acc;
  logic emg_hit;
  logic emg_dir_eff;
  logic entry;
  logic flash_edge;

  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      state_q     <= S_INIT;
      count_q     <= '0;
      nxt_dir_q   <= 1'b0;
      emg_pend_q  <= 1'b0;
      emg_dir_q   <= 1'b0;
      ped1_pend_q <= 1'b0;
      ped2_pend_q <= 1'b0;
      flash_q     <= 1'b0;
      lamp_q      <= L_INIT;
      walk1_q     <= 1'b0;
      walk2_q     <= 1'b0;
      emg_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      nxt_dir_q   <= nxt_dir_d;
      emg_pend_q  <= emg_pend_d;
      emg_dir_q   <= emg_dir_d;
      ped1_pend_q <= ped1_pend_d;
      ped2_pend_q <= ped2_pend_d;
      flash_q     <= flash_d;
      lamp_q      <= lamp_d;
      walk1_q     <= walk1_d;
      walk2_q     <= walk2_d;
      emg_act_q   <= emg_act_d;
    end
  end

  always_comb begin
    emg_acc     = emg_req && !emg_pend_q
                  && (state_q != S_EMG);
    emg_hit     = emg_pend_q || emg_acc;
    // a request accepted this very edge has not latched its direction yet
    emg_dir_eff = emg_pend_q ? emg_dir_q : emg_dir;
    flash_edge  = (state_q == S_FLASH)
                  && (count_q == C_FLASH);
    state_d     = state_q;
    nxt_dir_d   = nxt_dir_q;
    flash_d     = flash_q;

    unique case (state_q)
      S_INIT: state_d = S_ALLRED;
      S_ALLRED: begin
        if (count_q == C_CLEAR) begin
          if (emg_pend_q)      state_d = S_EMG;
          else if (night)      state_d = S_FLASH;
          else if (!nxt_dir_q) state_d = S_G1R2;
          else                 state_d = S_R1G2;
        end
      end
      S_G1R2: begin
        if (emg_hit)
          state_d = emg_dir_eff ? S_Y1R2 : S_EMG;
        else if (count_q == C_G1_MAX)
          state_d = S_Y1R2;
        else if (ped1_pend_q && count_q >= C_G_MIN)
          state_d = S_Y1R2;
      end
      S_Y1R2: begin
        if (count_q == C_Y) begin
          state_d   = S_ALLRED;
          nxt_dir_d = 1'b1;
        end
      end
      S_R1G2: begin
        if (emg_hit)
          state_d = emg_dir_eff ? S_EMG : S_R1Y2;
        else if (count_q == C_G2_MAX)
          state_d = S_R1Y2;
        else if (ped2_pend_q && count_q >= C_G_MIN)
          state_d = S_R1Y2;
      end
      S_R1Y2: begin
        if (count_q == C_Y) begin
          state_d   = S_ALLRED;
          nxt_dir_d = 1'b0;
        end
      end
      S_EMG: begin
        if (!emg_req)
          state_d = emg_dir_q ? S_R1Y2 : S_Y1R2;
      end
      S_FLASH: begin
        if (flash_edge) begin
          if (emg_pend_q || !night) begin
            state_d   = S_ALLRED;
            nxt_dir_d = 1'b0;
          end else begin
            flash_d = !flash_q;
          end
        end
      end
      default: state_d = S_INIT;
    endcase

    entry = (state_d != state_q);
    if (entry && state_d == S_FLASH)
      flash_d = 1'b1;

    if (entry || flash_edge)
      count_d = C_ONE;
    else if (state_q == S_EMG)
      count_d = count_q;
    else
      count_d = count_q + C_ONE;

    emg_pend_d = emg_pend_q;
    emg_dir_d  = emg_dir_q;
    if (emg_acc) begin
      emg_pend_d = 1'b1;
      emg_dir_d  = emg_dir;
    end
    if (entry && state_d == S_EMG)
      emg_pend_d = 1'b0;

    // clear on green entry overrides a same-edge request
    ped1_pend_d = ped1_pend_q;
    if (ped1_req && !walk1_q && state_q != S_FLASH)
      ped1_pend_d = 1'b1;
    if (entry && state_d == S_R1G2)
      ped1_pend_d = 1'b0;

    ped2_pend_d = ped2_pend_q;
    if (ped2_req && !walk2_q && state_q != S_FLASH)
      ped2_pend_d = 1'b1;
    if (entry && state_d == S_G1R2)
      ped2_pend_d = 1'b0;
  end

  always_comb begin
    lamp_d    = L_INIT;
    walk1_d   = 1'b0;
    walk2_d   = 1'b0;
    emg_act_d = 1'b0;
    unique case (state_d)
      S_INIT:   lamp_d = L_INIT;
      S_ALLRED: lamp_d = L_AR;
      S_G1R2: begin
        lamp_d  = L_G1;
        walk2_d = 1'b1;
      end
      S_Y1R2:   lamp_d = L_Y1;
      S_R1G2: begin
        lamp_d  = L_G2;
        walk1_d = 1'b1;
      end
      S_R1Y2:   lamp_d = L_Y2;
      S_EMG: begin
        lamp_d    = emg_dir_d ? L_G2 : L_G1;
        emg_act_d = 1'b1;
      end
      S_FLASH:
        lamp_d = {1'b0, flash_d, 2'b00, flash_d, 1'b0};
      default:  lamp_d = L_INIT;
    endcase
  end

  assign red1       = lamp_q[5];
  assign yellow1    = lamp_q[4];
  assign green1     = lamp_q[3];
  assign red2       = lamp_q[2];
  assign yellow2    = lamp_q[1];
  assign green2     = lamp_q[0];
  assign ped1_walk  = walk1_q;
  assign ped2_walk  = walk2_q;
  assign ped1_pend  = ped1_pend_q;
  assign ped2_pend  = ped2_pend_q;
  assign emg_active = emg_act_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios
// plus random stimulus against a phase-level reference model.
`timescale 1ns/1ps
module tb_traffic_phase_scheduler;

  localparam int CNT_W    = 12;
  localparam int T_CLEAR  = 4;
  localparam int T_G_MIN  = 6;
  localparam int T_G1_MAX = 20;
  localparam int T_G2_MAX = 16;
  localparam int T_Y      = 3;
  localparam int T_FLASH  = 2;

  typedef enum {P_INIT, P_AR, P_G1, P_Y1, P_G2, P_Y2, P_EMG, P_FL} ph_e;

  logic clk = 1'b0;
  logic ret = 1'b1;
  logic ped1_req = 1'b0, ped2_req = 1'b0;
  logic emg_req = 1'b0, emg_dir = 1'b0, night = 1'b0;
  logic red1, yellow1, green1, red2, yellow2, green2;
  logic ped1_walk, ped2_walk, ped1_pend, ped2_pend, emg_active;

  int checks = 0;
  int failures = 0;

  ph_e m_ph;
  int  m_t;
  bit  m_ep, m_ed, m_p1, m_p2, m_nr;

  traffic_phase_scheduler #(
    .CNT_W(CNT_W), .T_CLEAR(T_CLEAR), .T_G_MIN(T_G_MIN),
    .T_G1_MAX(T_G1_MAX), .T_G2_MAX(T_G2_MAX), .T_Y(T_Y),
    .T_FLASH(T_FLASH)
  ) dut (
    .clk(clk), .ret(ret),
    .ped1_req(ped1_req), .ped2_req(ped2_req),
    .emg_req(emg_req), .emg_dir(emg_dir), .night(night),
    .red1(red1), .yellow1(yellow1), .green1(green1),
    .red2(red2), .yellow2(yellow2), .green2(green2),
    .ped1_walk(ped1_walk), .ped2_walk(ped2_walk),
    .ped1_pend(ped1_pend), .ped2_pend(ped2_pend),
    .emg_active(emg_active)
  );

  always #5 clk = ~clk;

  initial begin
    if (T_G1_MAX >= (1 << CNT_W) || T_G2_MAX >= (1 << CNT_W)
        || T_CLEAR >= (1 << CNT_W) || T_Y >= (1 << CNT_W))
      $fatal(1, "duration exceeds counter width");
  end

  function automatic logic [10:0] dut_vec();
    return {red1, yellow1, green1, red2, yellow2, green2,
            ped1_walk, ped2_walk, ped1_pend, ped2_pend, emg_active};
  endfunction

  function automatic logic [10:0] mdl_vec();
    logic [5:0] l;
    logic w1, w2, ea, on;
    w1 = 0; w2 = 0; ea = 0; on = 0;
    case (m_ph)
      P_INIT: l = 6'b010010;
      P_AR:   l = 6'b100100;
      P_G1:   begin l = 6'b001100; w2 = 1; end
      P_Y1:   l = 6'b010100;
      P_G2:   begin l = 6'b100001; w1 = 1; end
      P_Y2:   l = 6'b100010;
      P_EMG:  begin l = m_ed ? 6'b100001 : 6'b001100; ea = 1; end
      default: begin
        on = (((m_t - 1) / T_FLASH) % 2) == 0;
        l = {1'b0, on, 2'b00, on, 1'b0};
      end
    endcase
    return {l, w1, w2, m_p1, m_p2, ea};
  endfunction

  task automatic model_reset();
    m_ph = P_INIT; m_t = 0;
    m_ep = 0; m_ed = 0; m_p1 = 0; m_p2 = 0; m_nr = 0;
  endtask

  task automatic model_step();
    ph_e nx;
    bit acc, hd;
    nx = m_ph;
    acc = emg_req && !m_ep && (m_ph != P_EMG);
    hd = m_ep ? m_ed : emg_dir;
    case (m_ph)
      P_INIT: nx = P_AR;
      P_AR: if (m_t == T_CLEAR) begin
        if (m_ep) nx = P_EMG;
        else if (night) nx = P_FL;
        else if (m_nr) nx = P_G2;
        else nx = P_G1;
      end
      P_G1: begin
        if (m_ep || acc) begin
          if (hd) nx = P_Y1; else nx = P_EMG;
        end else if (m_t == T_G1_MAX || (m_p1 && m_t >= T_G_MIN)) nx = P_Y1;
      end
      P_Y1: if (m_t == T_Y) begin nx = P_AR; m_nr = 1; end
      P_G2: begin
        if (m_ep || acc) begin
          if (hd) nx = P_EMG; else nx = P_Y2;
        end else if (m_t == T_G2_MAX || (m_p2 && m_t >= T_G_MIN)) nx = P_Y2;
      end
      P_Y2: if (m_t == T_Y) begin nx = P_AR; m_nr = 0; end
      P_EMG: if (!emg_req) begin
        if (m_ed) nx = P_Y2; else nx = P_Y1;
      end
      default: if ((m_t % T_FLASH) == 0 && (m_ep || !night)) begin
        nx = P_AR; m_nr = 0;
      end
    endcase
    if (ped1_req && m_ph != P_G2 && m_ph != P_FL) m_p1 = 1;
    if (ped2_req && m_ph != P_G1 && m_ph != P_FL) m_p2 = 1;
    if (nx == P_G2 && m_ph != P_G2) m_p1 = 0;
    if (nx == P_G1 && m_ph != P_G1) m_p2 = 0;
    if (acc) begin m_ep = 1; m_ed = emg_dir; end
    if (nx == P_EMG && m_ph != P_EMG) m_ep = 0;
    m_t = (nx != m_ph) ? 1 : m_t + 1;
    m_ph = nx;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #2 ret = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 11'b010010_00000) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", dut_vec(), 11'b010010_00000);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) ret = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_free_run();
    int g1run, g2run;
    logic pg1, pg2;
    g1run = 0; g2run = 0; pg1 = 0; pg2 = 0;
    for (int i = 0; i < 112; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL free_run cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
      checks++;
      if ((red1 + yellow1 + green1) != 1 || (red2 + yellow2 + green2) != 1) begin
        failures++;
        $display("FAIL one_lamp cyc=%0d got=%b exp=one per road", i, dut_vec());
      end
      if (green1) g1run++;
      if (green2) g2run++;
      if (pg1 && !green1) begin
        checks++;
        if (g1run != T_G1_MAX) begin
          failures++;
          $display("FAIL g1_len got=%0d exp=%0d", g1run, T_G1_MAX);
        end
        g1run = 0;
      end
      if (pg2 && !green2) begin
        checks++;
        if (g2run != T_G2_MAX) begin
          failures++;
          $display("FAIL g2_len got=%0d exp=%0d", g2run, T_G2_MAX);
        end
        g2run = 0;
      end
      pg1 = green1; pg2 = green2;
    end
  endtask

  task automatic test_ped_early();
    int n;
    for (int i = 0; i < 120 && !(m_ph == P_G1 && m_t == 2); i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL ped_early_wait got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    ped1_req = 1'b1;
    tick();
    ped1_req = 1'b0;
    checks++;
    if (ped1_pend !== 1'b1 || dut_vec() !== mdl_vec()) begin
      failures++;
      $display("FAIL ped1_latch got=%b exp=%b", dut_vec(), mdl_vec());
    end
    n = 0;
    while (green1 && n < 40) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL ped_early_run got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (n + 2 != T_G_MIN) begin
      failures++;
      $display("FAIL ped_early_g1_len got=%0d exp=%0d", n + 2, T_G_MIN);
    end
    n = 0;
    while (!green2 && n < 20) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL ped_early_to_g2 got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (!(green2 === 1'b1 && ped1_walk === 1'b1 && ped1_pend === 1'b0)) begin
      failures++;
      $display("FAIL ped1_serve got=%b exp=green2,walk1,nopend", dut_vec());
    end
  endtask

  task automatic test_ped_late();
    int n;
    for (int i = 0; i < 120 && !(m_ph == P_G1 && m_t == 10); i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL ped_late_wait got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    ped1_req = 1'b1;
    tick();
    ped1_req = 1'b0;
    n = 0;
    while (green1 && n < 40) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL ped_late_run got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL ped_late_exit got=%0d extra cycles exp=1", n);
    end
  endtask

  task automatic test_emergency();
    int n;
    for (int i = 0; i < 120 && !(m_ph == P_G1 && m_t == 5); i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL emg_wait got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    emg_req = 1'b1; emg_dir = 1'b1;
    tick();
    checks++;
    if (!(yellow1 === 1'b1 && red2 === 1'b1)) begin
      failures++;
      $display("FAIL emg_conflict_yellow got=%b exp=Y1R2", dut_vec());
    end
    n = 1;
    while (!emg_active && n < 20) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL emg_approach got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (n != T_Y + T_CLEAR + 1 || green2 !== 1'b1 || red1 !== 1'b1) begin
      failures++;
      $display("FAIL emg_entry cyc=%0d got=%b exp cyc=%0d R1G2", n, dut_vec(), T_Y + T_CLEAR + 1);
    end
    for (int i = n; i < 30; i++) begin
      if (i == 12) emg_dir = 1'b0;
      if (i == 20) emg_dir = 1'b1;
      if (i == 24) emg_dir = 1'b0;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec() || emg_active !== 1'b1 || green2 !== 1'b1) begin
        failures++;
        $display("FAIL emg_hold cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
    end
    emg_req = 1'b0;
    tick();
    checks++;
    if (!(red1 === 1'b1 && yellow2 === 1'b1 && emg_active === 1'b0)) begin
      failures++;
      $display("FAIL emg_release got=%b exp=R1Y2", dut_vec());
    end
    n = 0;
    while (!(green1 || green2) && n < 20) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL emg_exit got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (green1 !== 1'b1 || n != T_Y - 1 + T_CLEAR + 1) begin
      failures++;
      $display("FAIL emg_after_green got=%b n=%0d exp=G1 n=%0d", dut_vec(), n, T_Y + T_CLEAR);
    end
  endtask

  task automatic test_night();
    int n;
    logic [5:0] pat;
    pat = 6'b110011;
    for (int i = 0; i < 120 && m_ph != P_G2; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL night_wait got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    night = 1'b1;
    n = 0;
    while (!(yellow1 && yellow2) && n < 60) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL night_enter got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (yellow1 !== pat[5-k] || yellow2 !== pat[5-k] || red1 || red2) begin
        failures++;
        $display("FAIL flash_pat k=%0d got=%b exp_y=%b", k, dut_vec(), pat[5-k]);
      end
      tick();
    end
    night = 1'b0;
    n = 0;
    while (!(green1 || green2) && n < 20) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL night_leave got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (green1 !== 1'b1) begin
      failures++;
      $display("FAIL night_exit_g1 got=%b exp=G1R2", dut_vec());
    end
    night = 1'b1;
    n = 0;
    while (!(yellow1 && yellow2) && n < 60) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL night_reenter got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    emg_req = 1'b1; emg_dir = 1'b0;
    n = 0;
    while (!emg_active && n < 20) begin
      n++;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL flash_emg got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (emg_active !== 1'b1 || green1 !== 1'b1) begin
      failures++;
      $display("FAIL flash_emg_entry got=%b exp=EMG G1R2", dut_vec());
    end
    emg_req = 1'b0; night = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL flash_emg_exit got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 120 && !(m_ph == P_Y1 && m_t == 1); i++) begin
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL rst_wait got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    ped2_req = 1'b1;
    tick();
    ped2_req = 1'b0;
    checks++;
    if (ped2_pend !== 1'b1 || yellow1 !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=Y1R2 ped2_pend", dut_vec());
    end
    #3 ret = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 11'b010010_00000) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=%b", dut_vec(), 11'b010010_00000);
    end
    @(posedge clk);
    @(negedge clk) ret = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 11'b010010_00000) begin
      failures++;
      $display("FAIL rst_held got=%b exp=%b", dut_vec(), 11'b010010_00000);
    end
    tick();
    checks++;
    if (dut_vec() !== 11'b100100_00000 || dut_vec() !== mdl_vec()) begin
      failures++;
      $display("FAIL rst_allred got=%b exp=%b", dut_vec(), 11'b100100_00000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) emg_req = ~emg_req;
      emg_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) night = ~night;
      ped1_req = ($urandom_range(0, 15) == 0);
      ped2_req = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
    end
    emg_req = 1'b0; night = 1'b0; ped1_req = 1'b0; ped2_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_ped_early();
    test_ped_late();
    test_emergency();
    test_night();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Two-road intersection phase scheduler.
- Sequences the six lamp outputs through green / yellow / all-red phases with programmable durations.
- Arbitrates three request sources onto the light sequence: emergency pre-emption, night flash mode and pedestrian crossing buttons.
- Priority order: emergency > night > pedestrian.
- Sits between the button/sensor debouncers and the lamp drivers.

Parameters:
CNT_W, 12, phase counter width
T_CLEAR, 250, all-red clearance duration (cycles)
T_G_MIN, 500, minimum green before a pedestrian request may cut a green short
T_G1_MAX, 2500, full green duration, road 1
T_G2_MAX, 2250, full green duration, road 2
T_Y, 250, yellow duration (either road)
T_FLASH, 50, half-period of night yellow flash

Ports:
clk  in  1  system clock, rising edge
ret  in  1  asynchronous reset, active-low
ped1_req  in  1  pedestrian wants to cross road 1 (level, debounced)
ped2_req  in  1  pedestrian wants to cross road 2
emg_req  in  1  emergency pre-emption request (level)
emg_dir  in  1  direction to give green: 0 = road 1, 1 = road 2
night  in  1  night flash mode request (level)
red1,yellow1,green1  out  1 each  road 1 lamps
red2,yellow2,green2  out  1 each  road 2 lamps
ped1_walk,ped2_walk  out  1 each  walk signal, road 1 / road 2 crossing
ped1_pend,ped2_pend  out  1 each  pedestrian request latched, not yet served
emg_active  out  1  EMG hold state in progress

Behaviour:
- All outputs registered; lamps/walk/emg_active updated on the same edge as the state register.
- Reset (ret=0, async):
  - state=INIT, count=0, nxt_dir=0, emg_pend=0, emg_dir_q=0, ped*_pend=0.
  - yellow1=yellow2=1; all other outputs 0.
- count:
  - Loaded with 1 on every state entry; increments each cycle in the state.
  - A timed state exits on the edge where count==its duration, so it lasts exactly T cycles.
  - Never wraps: every duration must be < 2^CNT_W. The bench checks this at elaboration.
- States and lamps:
  - INIT: Y1,Y2 for 1 cycle, then ALLRED.
  - ALLRED: R1,R2 for T_CLEAR cycles. On exit, in priority order:
    - emg_pend → EMG;
    - else night → FLASH;
    - else nxt_dir=0 → G1R2;
    - else → R1G2.
  - G1R2: G1,R2; ped2_walk=1. Exits to Y1R2 at count==T_G1_MAX, or earlier at count>=T_G_MIN if ped1_pend. On entry, clear ped2_pend.
  - Y1R2: Y1,R2 for T_Y cycles → ALLRED; sets nxt_dir=1.
  - R1G2: R1,G2; ped1_walk=1. Mirror of G1R2: limit T_G2_MAX, cut short by ped2_pend. On entry, clear ped1_pend.
  - R1Y2: R1,Y2 for T_Y cycles → ALLRED; sets nxt_dir=0.
  - EMG: green on road emg_dir_q, red on the other; no walk. count frozen at 1. On emg_req=0, go to the yellow state of the held road (Y1R2 or R1Y2).
  - FLASH:
    - Y1=Y2 toggling every T_FLASH cycles, starting on; all other lamps 0.
    - At each toggle boundary: if emg_pend or night=0 → ALLRED with nxt_dir=0.
- Emergency:
  - Acceptance: when emg_req=1 and emg_pend=0 outside EMG, set emg_pend=1 and latch emg_dir_q=emg_dir.
  - emg_dir changes after acceptance are ignored until EMG exits.
  - Accepted in a green already matching emg_dir_q: go straight to EMG next cycle.
  - Accepted in a conflicting green: go immediately to that road's yellow, with full T_Y.
  - Accepted in yellow, ALLRED or FLASH: normal timing continues until the ALLRED exit, or the FLASH toggle boundary, picks EMG.
  - emg_pend cleared on EMG entry.
  - emg_req dropped before EMG entry: emg_pend stays set, and EMG is still entered for ≥1 cycle.
- Pedestrian:
  - pedN_pend sets whenever pedN_req=1, except while pedN_walk=1 (request already being served).
  - Pedestrian requests are ignored in FLASH; pend bits hold their value.
  - Simultaneous set and clear on the same edge: clear wins.
- Night is sampled only at the ALLRED exit and at FLASH toggle boundaries.
- Reset mid-phase: immediate INIT lamps; no completion of a yellow.

Test Plan:
(Sim overrides: T_CLEAR=4, T_G_MIN=6, T_G1_MAX=20, T_G2_MAX=16, T_Y=3, T_FLASH=2.)
1. Free run, no requests.
   → After reset: INIT 1 cycle, ALLRED 4, G1R2 20, Y1R2 3, ALLRED 4, R1G2 16, R1Y2 3, ALLRED 4, repeat.
   → Exactly one lamp per road on every cycle.
2. ped1_req pulsed 1 cycle at G1R2 count=2.
   → ped1_pend=1; G1R2 ends after count=6.
   → ped1_walk=1 throughout the following R1G2; ped1_pend clears on R1G2 entry.
3. ped1_req at G1R2 count=10.
   → G1R2 exits on the next cycle (count 11 ≥ 6).
4. emg_req=1, emg_dir=1 at G1R2 count=5, held 30 cycles.
   → Y1R2 3 cycles, ALLRED 4, EMG (R1,G2, emg_active=1) until release.
   → Then R1Y2 3, ALLRED 4, G1R2.
   → emg_dir toggled during EMG has no effect.
5. night=1 during R1G2.
   → Normal cycle until the next ALLRED exit, then FLASH with Y1=Y2 pattern 1,1,0,0,….
   → night=0 → ALLRED at the next toggle boundary → G1R2.
   → emg_req during FLASH → ALLRED → EMG.
6. ret low at Y1R2 count=2 (asynchronous, mid-cycle).
   → Outputs go to Y1,Y2 immediately, all else 0; pend bits cleared; after release, INIT → ALLRED.
